// File: rtl/shift_load_ctrl.sv
// ============================================================================
// shift_load_ctrl : paces a parallel word LSB-first into a right-shift register
// Rev 1.0
// ============================================================================
`default_nettype none

module shift_load_ctrl #(
   parameter int WIDTH = 16,
   parameter int DIV   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   input  logic             abort,
   output logic             step,
   output logic             ld,
   output logic             busy,
   output logic             done,
   output logic [4:0]       bit_cnt
);

   localparam int             PW         = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
   localparam logic [4:0]     CNT_LAST   = 5'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic             step_q, step_d;
   logic             ld_q, ld_d;
   logic             done_q, done_d;
   logic [4:0]       bit_cnt_q, bit_cnt_d;
   logic             accept;

   // DONE accepts a new start just like IDLE so loads can run back-to-back
   assign accept = start & ~abort & (state_q != ST_SHIFT);

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      presc_d   = presc_q;
      step_d    = step_q;
      ld_d      = 1'b0;
      done_d    = 1'b0;
      bit_cnt_d = bit_cnt_q;

      case (state_q)
         ST_SHIFT: begin
            if (abort) begin
               state_d   = ST_IDLE;
               bit_cnt_d = 5'd0;
            end else begin
               presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
               if (presc_q == PRESC_LAST) begin
                  ld_d      = 1'b1;
                  step_d    = hold_q[0];
                  hold_d    = {1'b0, hold_q[WIDTH-1:1]};
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == CNT_LAST)
                     state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: ;
      endcase

      if (accept) begin
         state_d   = ST_SHIFT;
         hold_d    = data_in;
         presc_d   = '0;
         bit_cnt_d = 5'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         hold_q    <= '0;
         presc_q   <= '0;
         step_q    <= 1'b0;
         ld_q      <= 1'b0;
         done_q    <= 1'b0;
         bit_cnt_q <= 5'd0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         presc_q   <= presc_d;
         step_q    <= step_d;
         ld_q      <= ld_d;
         done_q    <= done_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign step    = step_q;
   assign ld      = ld_q;
   assign done    = done_q;
   assign bit_cnt = bit_cnt_q;
   assign busy    = (state_q == ST_SHIFT);

endmodule

`default_nettype wire
